// File: rtl/cpu_pkg.sv
// Shared CPU definitions: multiplier status codes seen by the register file and
// hazard unit, the multiplier state set, and the default datapath width.
package cpu_pkg;

  localparam int MUL_WIDTH = 32;

  localparam logic [1:0] MUL_IDLE = 2'b00;
  localparam logic [1:0] MUL_RUN  = 2'b01;
  localparam logic [1:0] MUL_DONE = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/multu_seq_if.sv
// EX-stage multiplier bundle: issue operands in, status and HI/LO read-back out.
interface multu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             hilo_sel;
  logic [1:0]       mul;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hilo_out;

  modport master (
    output start, op_a, op_b, hilo_sel,
    input  mul, busy, hi, lo, hilo_out
  );

  modport slave (
    input  start, op_a, op_b, hilo_sel,
    output mul, busy, hi, lo, hilo_out
  );
endinterface

// File: rtl/multu_seq_hilo_reg.sv
// HI/LO architectural registers with a single load strobe and the MFHI/MFLO read mux.
module hilo_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  input  logic             i_sel,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_out
);

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (i_load) begin
      r_hi <= i_hi;
      r_lo <= i_lo;
    end
  end

  assign o_hi  = r_hi;
  assign o_lo  = r_lo;
  assign o_out = i_sel ? r_hi : r_lo;

endmodule

// File: rtl/multu_seq.sv
// Shift-add unsigned multiplier: one partial-product step per cycle, WIDTH steps,
// then a single DONE cycle that commits the product into HI/LO.
module multu_seq
  import cpu_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  multu_seq_if.slave  bus
);

  // state   | meaning
  // S_IDLE  | waiting for a MULTU issue
  // S_RUN   | one shift-add iteration per cycle, stall requested
  // S_DONE  | product complete, HI/LO load on the leaving edge
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH:0]     w_sum;
  logic               w_last;
  logic               w_load;

  // Carry is kept in w_sum[WIDTH] and shifts into the top of the accumulator.
  always_comb begin
    w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]};
    if (r_acc[0]) w_sum = w_sum + {1'b0, r_mcand};
  end

  assign w_last = (r_cnt == CNT_W'(WIDTH-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_mcand <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_mcand <= bus.op_a;
            r_acc   <= {{WIDTH{1'b0}}, bus.op_b};
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc <= {w_sum, r_acc[WIDTH-1:1]};
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_load   = (r_state == S_DONE);
  assign bus.busy = (r_state == S_RUN);
  assign bus.mul  = (r_state == S_RUN)  ? MUL_RUN  :
                    (r_state == S_DONE) ? MUL_DONE : MUL_IDLE;

  hilo_reg #(.WIDTH(WIDTH)) u_hilo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_hi   (r_acc[2*WIDTH-1:WIDTH]),
    .i_lo   (r_acc[WIDTH-1:0]),
    .i_sel  (bus.hilo_sel),
    .o_hi   (bus.hi),
    .o_lo   (bus.lo),
    .o_out  (bus.hilo_out)
  );

endmodule

// File: tb/tb_multu_seq.sv
// Self-checking bench for multu_seq: directed table, randomized products against
// plain 64-bit arithmetic, and hand sequences for restart, reset-abort and back-to-back.
module tb_multu_seq;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  multu_seq_if #(.WIDTH(32)) bus ();

  multu_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
    return 64'(a) * 64'(b);
  endfunction

  // Issue one MULTU and follow it to completion; optionally disturb operands/start mid-run.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo,
                         input bit disturb, input string name);
    int n = 0;
    int hold_bad = 0;
    bit done = 0;
    @(negedge clk);
    bus.op_a  = a;
    bus.op_b  = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (bus.mul == MUL_RUN) begin
        n++;
        if (!bus.busy || bus.hi !== exp_hi || bus.lo !== exp_lo) hold_bad++;
        if (disturb && (n == 5 || n == 20)) begin
          bus.op_a  = $urandom;
          bus.op_b  = $urandom;
          bus.start = 1'b1;
        end else begin
          bus.start = 1'b0;
        end
      end else begin
        done = 1;
      end
    end
    bus.start = 1'b0;
    chk({name, "_busy_len"}, 64'(n), 64'd32);
    chk({name, "_hold_old"}, 64'(hold_bad), 64'd0);
    chk({name, "_done_mul"}, 64'(bus.mul), 64'(MUL_DONE));
    chk({name, "_done_busy"}, 64'(bus.busy), 64'd0);
    @(negedge clk);
    exp_hi = ehi;
    exp_lo = elo;
    chk({name, "_idle_mul"}, 64'(bus.mul), 64'(MUL_IDLE));
    chk({name, "_hi"}, 64'(bus.hi), 64'(ehi));
    chk({name, "_lo"}, 64'(bus.lo), 64'(elo));
    bus.hilo_sel = 1'b1;
    #1 chk({name, "_mfhi"}, 64'(bus.hilo_out), 64'(ehi));
    bus.hilo_sel = 1'b0;
    #1 chk({name, "_mflo"}, 64'(bus.hilo_out), 64'(elo));
  endtask

  initial begin
    logic [63:0] p;
    logic [31:0] ra, rb;
    int bad_pulse;
    bit seen;

    tbl[0] = '{32'd3,        32'd5,        32'd0,          32'd15,         "m3x5"};
    tbl[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE,   32'h00000001,   "max"};
    tbl[2] = '{32'd0,        32'hDEADBEEF, 32'd0,          32'd0,          "zero"};
    tbl[3] = '{32'd7,        32'd6,        32'd0,          32'd42,         "m7x6"};

    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.hilo_sel = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    repeat (2) @(negedge clk);
    chk("rst_mul", 64'(bus.mul), 64'(MUL_IDLE));
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++)
      run_mul(tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, 1'b0, tbl[i].name);

    // Reset during RUN aborts the multiply and clears HI/LO immediately.
    @(negedge clk);
    bus.op_a = 32'd2;
    bus.op_b = 32'd2;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_running", 64'(bus.mul), 64'(MUL_RUN));
    chk("abort_lo_before", 64'(bus.lo), 64'd42);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_mul", 64'(bus.mul), 64'(MUL_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    exp_hi = '0;
    exp_lo = '0;
    bad_pulse = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.mul != MUL_IDLE || bus.busy) bad_pulse++;
    end
    chk("abort_no_done", 64'(bad_pulse), 64'd0);
    chk("abort_hilo_after", {bus.hi, bus.lo}, 64'd0);

    // Operands and start toggled mid-run must not disturb the product in flight.
    p = model(32'h12345678, 32'h9ABCDEF0);
    run_mul(32'h12345678, 32'h9ABCDEF0, p[63:32], p[31:0], 1'b1, "disturb");

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 0) rb = 32'hFFFFFFFF;
      p = model(ra, rb);
      run_mul(ra, rb, p[63:32], p[31:0], 1'b0, $sformatf("rand%0d", i));
    end

    // start held high: second MULTU taken from IDLE after one idle cycle.
    @(negedge clk);
    bus.op_a = 32'd4;
    bus.op_b = 32'd4;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.op_a = 32'd9;
    bus.op_b = 32'd11;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      if (i < 32)       chk($sformatf("b2b_mul%0d", i), 64'(bus.mul), 64'(MUL_RUN));
      else if (i == 32) chk("b2b_done", 64'(bus.mul), 64'(MUL_DONE));
      else if (i == 33) begin
        chk("b2b_gap", 64'(bus.mul), 64'(MUL_IDLE));
        chk("b2b_first", {bus.hi, bus.lo}, model(32'd4, 32'd4));
      end else chk("b2b_restart", 64'(bus.mul), 64'(MUL_RUN));
    end
    bus.start = 1'b0;
    seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (bus.mul == MUL_DONE) seen = 1;
    end
    chk("b2b_second_done_seen", 64'(seen), 64'd1);
    @(negedge clk);
    chk("b2b_second", {bus.hi, bus.lo}, model(32'd9, 32'd11));
    chk("b2b_end_idle", 64'(bus.mul), 64'(MUL_IDLE));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
